fp8_matrix_loader: RTL

- Upstream operand stage for the 3x3 FP8 matrix multiplier.
- Accepts a byte stream of 18 FP8 elements over a valid/ready handshake: A in row-major order, then B in row-major order.
- Presents both matrices as stable parallel flat buses, with a valid/ack handshake toward the multiplier.
- Double-buffered: the next frame loads into a shadow buffer while the current matrices are held on the outputs.

---
 rtl/fp8_pkg.sv | 19 +
 rtl/fp8_canon.sv | 17 +
 rtl/fp8_matrix_loader.sv | 89 ++++++++
 3 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: element width, field positions, matrix geometry.
package fp8_pkg;

  localparam int FP8_W        = 8;
  localparam int FP8_EXP_BIAS = 3;
  localparam int MAT_N        = 3;
  localparam int MAT_ELEMS    = MAT_N * MAT_N;

  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 4;
  localparam int MAN_MSB  = 3;
  localparam int MAN_LSB  = 0;

  localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;

  typedef logic [FP8_W-1:0] fp8_t;

endpackage

// File: rtl/fp8_canon.sv
// FP8 zero canonicaliser: any element with a zero exponent field becomes +0.
module fp8_canon
  import fp8_pkg::*;
(
  input  logic [FP8_W-1:0] din,
  output logic [FP8_W-1:0] dout
);

  // Flush zero-exponent encodings (both signs, any mantissa) to FP8_ZERO.
  always_comb begin
    dout = din;
    if (din[EXP_MSB:EXP_LSB] == '0) begin
      dout = FP8_ZERO;
    end
  end

endmodule

// File: rtl/fp8_matrix_loader.sv
// Double-buffered 3x3 FP8 operand loader: byte stream in (A then B, row-major),
// parallel flat matrices out with a valid/ack handshake.
// Optional: define FP8_FLUSH_ZERO_EN to store zero-exponent elements as 0x00.
module fp8_matrix_loader
  import fp8_pkg::*;
#(
  parameter int DATA_W = FP8_W,
  parameter int N      = MAT_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [N*N*DATA_W-1:0] a_flat,
  output logic [N*N*DATA_W-1:0] b_flat,
  output logic                  mat_valid,
  input  logic                  mat_ack,
  output logic                  err_sof
);

  localparam int ELEMS = N * N;
  localparam int FRAME = 2 * ELEMS;
  localparam int IDX_W = $clog2(FRAME);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME - 1);

  logic [IDX_W-1:0]              idx;
  // The final element bypasses the shadow, so only FRAME-1 slots are kept.
  logic [FRAME-2:0][DATA_W-1:0]  shadow;
  logic [DATA_W-1:0]             elem;
  logic                          xfer;
  logic                          last_xfer;

`ifdef FP8_FLUSH_ZERO_EN
  fp8_canon u_canon (
    .din  (in_data),
    .dout (elem)
  );
`else
  assign elem = in_data;
`endif

  // Handshake: stall only when the last element would overwrite unacknowledged outputs.
  always_comb begin
    in_ready  = !reset && !((idx == LAST) && mat_valid && !mat_ack);
    xfer      = in_valid && in_ready;
    last_xfer = xfer && !in_sof && (idx == LAST);
  end

  // Element counter and shadow buffer; in_sof restarts the frame at slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      shadow  <= '0;
      err_sof <= 1'b0;
    end else begin
      err_sof <= 1'b0;
      if (xfer) begin
        if (in_sof) begin
          shadow[0] <= elem;
          idx       <= IDX_W'(1);
          err_sof   <= (idx != '0);
        end else if (idx == LAST) begin
          idx <= '0;
        end else begin
          shadow[idx] <= elem;
          idx         <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Output registers: publish a whole frame on its last element, clear valid on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_flat    <= '0;
      b_flat    <= '0;
      mat_valid <= 1'b0;
    end else if (last_xfer) begin
      a_flat    <= shadow[ELEMS-1:0];
      b_flat    <= {elem, shadow[FRAME-2:ELEMS]};
      mat_valid <= 1'b1;
    end else if (mat_ack) begin
      mat_valid <= 1'b0;
    end
  end

endmodule
